id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register of the RV32IM 5-stage pipeline.
- Latches decoded operands and control fields from ID into EX.
- Acts on the load-use hazard signal by inserting a one-cycle NOP bubble, kills the ID instruction on a taken branch or jump flush, and freezes while EX is busy with a multi-cycle MUL/DIV.
- Keeps saturating bubble and flush counters for performance analysis.

---
 rtl/pipeline_pkg.sv | 38 +++
 rtl/sat_counter.sv | 32 +++
 rtl/id_ex_pipe_reg.sv | 159 +++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: field widths, the ID/EX bundle and its NOP value.
// Imported by every pipeline-stage file.
package pipeline_pkg;

    localparam int ALU_OP_W   = 5;
    localparam int MEM_RD_W   = 4;
    localparam int MEM_WR_W   = 3;
    localparam int BJ_W       = 4;
    localparam int REG_ADDR_W = 5;

    localparam logic [ALU_OP_W-1:0] ALU_NOP = '0;
    localparam logic [MEM_RD_W-1:0] MRD_NONE = '0;
    localparam logic [MEM_WR_W-1:0] MWR_NONE = '0;
    localparam logic [BJ_W-1:0]     BJ_NONE = '0;

    typedef struct packed {
        logic                  valid;
        logic [31:0]           pc;
        logic [31:0]           data1;
        logic [31:0]           data2;
        logic [31:0]           imm;
        logic [REG_ADDR_W-1:0] addr1;
        logic [REG_ADDR_W-1:0] addr2;
        logic [REG_ADDR_W-1:0] w_addr;
        logic                  op1_sel;
        logic                  op2_sel;
        logic [ALU_OP_W-1:0]   alu_op;
        logic [MEM_RD_W-1:0]   mem_read;
        logic [MEM_WR_W-1:0]   mem_write;
        logic [BJ_W-1:0]       branch_jump;
        logic                  reg_write;
    } id_ex_t;

    // All-zero bubble: mem_read=0 and w_addr=0 so the load-use
    // hazard cannot re-trigger on the bubble itself.
    localparam id_ex_t ID_EX_NOP = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins).
// Ports: clk_i, clr_i, inc_i in; cnt_o out (W bits).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with hold, flush and load-use bubble insertion.
// Ports: CLK, RESET, HOLD, LU_HAZ_SIG, FLUSH, ID_* in; EX_*, counters out.
module id_ex_pipe_reg
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  HOLD,
    input  logic                  LU_HAZ_SIG,
    input  logic                  FLUSH,
    input  logic                  ID_VALID,
    input  logic [31:0]           ID_PC,
    input  logic [31:0]           ID_DATA1,
    input  logic [31:0]           ID_DATA2,
    input  logic [31:0]           ID_IMM,
    input  logic [REG_ADDR_W-1:0] ID_ADDR1,
    input  logic [REG_ADDR_W-1:0] ID_ADDR2,
    input  logic [REG_ADDR_W-1:0] ID_W_ADDR,
    input  logic                  ID_OP1_SEL,
    input  logic                  ID_OP2_SEL,
    input  logic [ALU_OP_W-1:0]   ID_ALU_OP,
    input  logic [MEM_RD_W-1:0]   ID_MEM_READ,
    input  logic [MEM_WR_W-1:0]   ID_MEM_WRITE,
    input  logic [BJ_W-1:0]       ID_BRANCH_JUMP,
    input  logic                  ID_REG_WRITE,
    output logic                  EX_VALID,
    output logic [31:0]           EX_PC,
    output logic [31:0]           EX_DATA1,
    output logic [31:0]           EX_DATA2,
    output logic [31:0]           EX_IMM,
    output logic [REG_ADDR_W-1:0] EX_ADDR1,
    output logic [REG_ADDR_W-1:0] EX_ADDR2,
    output logic [REG_ADDR_W-1:0] EX_W_ADDR,
    output logic                  EX_OP1_SEL,
    output logic                  EX_OP2_SEL,
    output logic [ALU_OP_W-1:0]   EX_ALU_OP,
    output logic [MEM_RD_W-1:0]   EX_MEM_READ,
    output logic [MEM_WR_W-1:0]   EX_MEM_WRITE,
    output logic [BJ_W-1:0]       EX_BRANCH_JUMP,
    output logic                  EX_REG_WRITE,
    output logic                  EX_IS_BUBBLE,
    output logic [CNT_W-1:0]      BUBBLE_CNT,
    output logic [CNT_W-1:0]      FLUSH_CNT
);

    typedef enum logic {
        RUN,
        FROZEN
    } state_e;

    state_e state_q;
    state_e state_d;

    id_ex_t id_b;
    id_ex_t ex_q;
    id_ex_t ex_d;
    logic   bub_q;
    logic   bub_d;
    logic   bub_inc;
    logic   flush_inc;

    always_comb begin
        id_b             = ID_EX_NOP;
        id_b.valid       = ID_VALID;
        id_b.pc          = ID_PC;
        id_b.data1       = ID_DATA1;
        id_b.data2       = ID_DATA2;
        id_b.imm         = ID_IMM;
        id_b.addr1       = ID_ADDR1;
        id_b.addr2       = ID_ADDR2;
        id_b.w_addr      = ID_W_ADDR;
        id_b.op1_sel     = ID_OP1_SEL;
        id_b.op2_sel     = ID_OP2_SEL;
        id_b.alu_op      = ID_ALU_OP;
        id_b.mem_read    = ID_MEM_READ;
        id_b.mem_write   = ID_MEM_WRITE;
        id_b.branch_jump = ID_BRANCH_JUMP;
        id_b.reg_write   = ID_REG_WRITE;
    end

    // Freeze tracking; leaving FROZEN needs no special action, the
    // release edge simply takes the normal priority path below.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:    if (HOLD)  state_d = FROZEN;
            FROZEN: if (!HOLD) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        ex_d      = ex_q;
        bub_d     = bub_q;
        bub_inc   = 1'b0;
        flush_inc = 1'b0;
        if (HOLD) begin
            ex_d  = ex_q;
            bub_d = bub_q;
        end else if (FLUSH) begin
            ex_d      = ID_EX_NOP;
            bub_d     = 1'b0;
            flush_inc = 1'b1;
        end else if (LU_HAZ_SIG) begin
            ex_d    = ID_EX_NOP;
            bub_d   = 1'b1;
            bub_inc = 1'b1;
        end else begin
            ex_d  = id_b;
            bub_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= RUN;
            ex_q    <= ID_EX_NOP;
            bub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            bub_q   <= bub_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_bub_cnt (
        .clk_i (CLK),
        .clr_i (RESET),
        .inc_i (bub_inc),
        .cnt_o (BUBBLE_CNT)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (CLK),
        .clr_i (RESET),
        .inc_i (flush_inc),
        .cnt_o (FLUSH_CNT)
    );

    assign EX_VALID       = ex_q.valid;
    assign EX_PC          = ex_q.pc;
    assign EX_DATA1       = ex_q.data1;
    assign EX_DATA2       = ex_q.data2;
    assign EX_IMM         = ex_q.imm;
    assign EX_ADDR1       = ex_q.addr1;
    assign EX_ADDR2       = ex_q.addr2;
    assign EX_W_ADDR      = ex_q.w_addr;
    assign EX_OP1_SEL     = ex_q.op1_sel;
    assign EX_OP2_SEL     = ex_q.op2_sel;
    assign EX_ALU_OP      = ex_q.alu_op;
    assign EX_MEM_READ    = ex_q.mem_read;
    assign EX_MEM_WRITE   = ex_q.mem_write;
    assign EX_BRANCH_JUMP = ex_q.branch_jump;
    assign EX_REG_WRITE   = ex_q.reg_write;
    assign EX_IS_BUBBLE   = bub_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg (CNT_W=16 and CNT_W=2 instances).
// Both instances share stimulus; the narrow one checks saturation.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, hold, lu, flush;
    logic        id_valid;
    logic [31:0] id_pc, id_d1, id_d2, id_imm;
    logic [4:0]  id_a1, id_a2, id_wa;
    logic        id_s1, id_s2;
    logic [4:0]  id_alu;
    logic [3:0]  id_mrd;
    logic [2:0]  id_mwr;
    logic [3:0]  id_bj;
    logic        id_rw;

    logic        ex_valid, ex_s1, ex_s2, ex_rw, ex_bub;
    logic [31:0] ex_pc, ex_d1, ex_d2, ex_imm;
    logic [4:0]  ex_a1, ex_a2, ex_wa, ex_alu;
    logic [3:0]  ex_mrd, ex_bj;
    logic [2:0]  ex_mwr;
    logic [15:0] bcnt, fcnt;

    logic        y_valid, y_s1, y_s2, y_rw, y_bub;
    logic [31:0] y_pc, y_d1, y_d2, y_imm;
    logic [4:0]  y_a1, y_a2, y_wa, y_alu;
    logic [3:0]  y_mrd, y_bj;
    logic [2:0]  y_mwr;
    logic [1:0]  y_bcnt, y_fcnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.CNT_W(16)) u_dut (
        .CLK(clk), .RESET(rst), .HOLD(hold), .LU_HAZ_SIG(lu),
        .FLUSH(flush), .ID_VALID(id_valid), .ID_PC(id_pc),
        .ID_DATA1(id_d1), .ID_DATA2(id_d2), .ID_IMM(id_imm),
        .ID_ADDR1(id_a1), .ID_ADDR2(id_a2), .ID_W_ADDR(id_wa),
        .ID_OP1_SEL(id_s1), .ID_OP2_SEL(id_s2), .ID_ALU_OP(id_alu),
        .ID_MEM_READ(id_mrd), .ID_MEM_WRITE(id_mwr),
        .ID_BRANCH_JUMP(id_bj), .ID_REG_WRITE(id_rw),
        .EX_VALID(ex_valid), .EX_PC(ex_pc), .EX_DATA1(ex_d1),
        .EX_DATA2(ex_d2), .EX_IMM(ex_imm), .EX_ADDR1(ex_a1),
        .EX_ADDR2(ex_a2), .EX_W_ADDR(ex_wa), .EX_OP1_SEL(ex_s1),
        .EX_OP2_SEL(ex_s2), .EX_ALU_OP(ex_alu), .EX_MEM_READ(ex_mrd),
        .EX_MEM_WRITE(ex_mwr), .EX_BRANCH_JUMP(ex_bj),
        .EX_REG_WRITE(ex_rw), .EX_IS_BUBBLE(ex_bub),
        .BUBBLE_CNT(bcnt), .FLUSH_CNT(fcnt)
    );

    id_ex_pipe_reg #(.CNT_W(2)) u_dut2 (
        .CLK(clk), .RESET(rst), .HOLD(hold), .LU_HAZ_SIG(lu),
        .FLUSH(flush), .ID_VALID(id_valid), .ID_PC(id_pc),
        .ID_DATA1(id_d1), .ID_DATA2(id_d2), .ID_IMM(id_imm),
        .ID_ADDR1(id_a1), .ID_ADDR2(id_a2), .ID_W_ADDR(id_wa),
        .ID_OP1_SEL(id_s1), .ID_OP2_SEL(id_s2), .ID_ALU_OP(id_alu),
        .ID_MEM_READ(id_mrd), .ID_MEM_WRITE(id_mwr),
        .ID_BRANCH_JUMP(id_bj), .ID_REG_WRITE(id_rw),
        .EX_VALID(y_valid), .EX_PC(y_pc), .EX_DATA1(y_d1),
        .EX_DATA2(y_d2), .EX_IMM(y_imm), .EX_ADDR1(y_a1),
        .EX_ADDR2(y_a2), .EX_W_ADDR(y_wa), .EX_OP1_SEL(y_s1),
        .EX_OP2_SEL(y_s2), .EX_ALU_OP(y_alu), .EX_MEM_READ(y_mrd),
        .EX_MEM_WRITE(y_mwr), .EX_BRANCH_JUMP(y_bj),
        .EX_REG_WRITE(y_rw), .EX_IS_BUBBLE(y_bub),
        .BUBBLE_CNT(y_bcnt), .FLUSH_CNT(y_fcnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; lu = 1'b0; flush = 1'b0;
        id_valid = 1'b0; id_pc = 32'h0; id_d1 = 32'h0;
        id_d2 = 32'h0; id_imm = 32'h0; id_a1 = 5'd0;
        id_a2 = 5'd0; id_wa = 5'd0; id_s1 = 1'b0; id_s2 = 1'b0;
        id_alu = 5'd0; id_mrd = 4'd0; id_mwr = 3'd0;
        id_bj = 4'd0; id_rw = 1'b0;

        step();
        chk("rst_pc", ex_pc, 32'h0);
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_bub", {31'd0, ex_bub}, 32'd0);
        chk("rst_bcnt", {16'd0, bcnt}, 32'd0);
        chk("rst_fcnt", {16'd0, fcnt}, 32'd0);

        rst = 1'b0; id_valid = 1'b1; id_pc = 32'h100;
        id_wa = 5'd5; id_rw = 1'b1; id_d1 = 32'h1111;
        id_imm = 32'hFFFF_FFF0; id_alu = 5'd3; id_s2 = 1'b1;
        step();
        chk("ld_pc", ex_pc, 32'h100);
        chk("ld_wa", {27'd0, ex_wa}, 32'd5);
        chk("ld_rw", {31'd0, ex_rw}, 32'd1);
        chk("ld_bub", {31'd0, ex_bub}, 32'd0);
        chk("ld_d1", ex_d1, 32'h1111);
        chk("ld_imm", ex_imm, 32'hFFFF_FFF0);
        chk("ld_alu", {27'd0, ex_alu}, 32'd3);
        chk("ld_s2", {31'd0, ex_s2}, 32'd1);

        id_pc = 32'h104; id_mrd = 4'd2; id_wa = 5'd2;
        id_alu = 5'd0; id_s2 = 1'b1;
        step();
        chk("lw_mrd", {28'd0, ex_mrd}, 32'd2);

        id_pc = 32'h108; id_mrd = 4'd0; id_wa = 5'd3;
        id_a1 = 5'd2; id_s2 = 1'b0; lu = 1'b1;
        step();
        chk("bub_pc", ex_pc, 32'h0);
        chk("bub_wa", {27'd0, ex_wa}, 32'd0);
        chk("bub_mrd", {28'd0, ex_mrd}, 32'd0);
        chk("bub_rw", {31'd0, ex_rw}, 32'd0);
        chk("bub_imm", ex_imm, 32'h0);
        chk("bub_flag", {31'd0, ex_bub}, 32'd1);
        chk("bub_cnt", {16'd0, bcnt}, 32'd1);

        lu = 1'b0;
        step();
        chk("after_bub_pc", ex_pc, 32'h108);
        chk("after_bub_a1", {27'd0, ex_a1}, 32'd2);
        chk("after_bub_flag", {31'd0, ex_bub}, 32'd0);

        id_pc = 32'h10C; flush = 1'b1; lu = 1'b1;
        step();
        chk("fl_pc", ex_pc, 32'h0);
        chk("fl_flag", {31'd0, ex_bub}, 32'd0);
        chk("fl_fcnt", {16'd0, fcnt}, 32'd1);
        chk("fl_bcnt", {16'd0, bcnt}, 32'd1);

        flush = 1'b0; lu = 1'b0; id_pc = 32'h110;
        step();
        chk("pre_hold_pc", ex_pc, 32'h110);

        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            id_pc = 32'h114 + 32'(i * 4);
            flush = (i % 2 == 0);
            lu = (i == 1);
            step();
            chk("hold_pc", ex_pc, 32'h110);
            chk("hold_wa", {27'd0, ex_wa}, 32'd3);
            chk("hold_fcnt", {16'd0, fcnt}, 32'd1);
            chk("hold_bcnt", {16'd0, bcnt}, 32'd1);
        end

        hold = 1'b0; flush = 1'b0; lu = 1'b0; id_pc = 32'h124;
        step();
        chk("release_pc", ex_pc, 32'h124);

        id_pc = 32'h200;
        step();
        chk("pc200", ex_pc, 32'h200);
        hold = 1'b1; id_pc = 32'h204;
        step();
        chk("hold200", ex_pc, 32'h200);
        rst = 1'b1;
        step();
        chk("rst_hold_pc", ex_pc, 32'h0);
        chk("rst_hold_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_hold_bcnt", {16'd0, bcnt}, 32'd0);
        chk("rst_hold_fcnt", {16'd0, fcnt}, 32'd0);
        chk("rst_hold_bcnt2", {30'd0, y_bcnt}, 32'd0);

        rst = 1'b0; hold = 1'b0; id_pc = 32'h300;
        step();
        chk("post_rst_pc", ex_pc, 32'h300);
        chk("post_rst_pc2", y_pc, 32'h300);

        lu = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("sat_bcnt16", {16'd0, bcnt}, 32'(i));
            chk("sat_bcnt2", {30'd0, y_bcnt}, (i < 3) ? 32'(i) : 32'd3);
            chk("sat_flag", {31'd0, ex_bub}, 32'd1);
        end
        lu = 1'b0;
        step();
        chk("sat_hold_val", {30'd0, y_bcnt}, 32'd3);
        chk("sat_fcnt2", {30'd0, y_fcnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
